// File: rtl/riscv_tpr_update_ctrl.sv
// TPR update controller: stages CSR writes in a shadow register, drains in-flight stores, then swaps the active policy.
// Optional sticky lock on bit 31 of the active policy when TPR_LOCK_EN is defined.
module riscv_tpr_update_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter logic [31:0] TPR_RESET    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tpr_we_i,
    input  logic [31:0] tpr_wdata_i,
    input  logic        id_is_store_i,
    input  logic        ex_store_busy_i,
    output logic [31:0] tpr_o,
    output logic [31:0] tpr_shadow_o,
    output logic        stall_store_o,
    output logic        update_busy_o,
    output logic        update_done_o,
    output logic        tpr_write_err_o
);

    localparam int unsigned CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   tpr_reg, tpr_next;
    logic [31:0]   shadow_reg, shadow_next;
    logic          busy_reg, done_reg, err_reg;
    logic          we_acc, we_rej;

`ifdef TPR_LOCK_EN
    // A committed bit 31 blocks every further write until reset.
    assign we_acc = tpr_we_i & ~tpr_reg[31];
    assign we_rej = tpr_we_i &  tpr_reg[31];
`else
    assign we_acc = tpr_we_i;
    assign we_rej = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        tpr_next    = tpr_reg;
        shadow_next = shadow_reg;
        case (state_reg)
            IDLE: begin
                if (we_acc) begin
                    shadow_next = tpr_wdata_i;
                    cnt_next    = CNT_LOAD;
                    state_next  = DRAIN;
                end
            end
            DRAIN: begin
                // A new write restarts the drain window; the last write wins.
                if (we_acc) begin
                    shadow_next = tpr_wdata_i;
                    cnt_next    = CNT_LOAD;
                end else if (ex_store_busy_i) begin
                    cnt_next = cnt_reg;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                // Commit the pre-write shadow; a write here starts a fresh drain.
                tpr_next = shadow_reg;
                if (we_acc) begin
                    shadow_next = tpr_wdata_i;
                    cnt_next    = CNT_LOAD;
                    state_next  = DRAIN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            tpr_reg    <= TPR_RESET;
            shadow_reg <= TPR_RESET;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            tpr_reg    <= tpr_next;
            shadow_reg <= shadow_next;
            busy_reg   <= (state_next != IDLE);
            done_reg   <= (state_next == COMMIT);
            err_reg    <= we_rej;
        end
    end

    assign tpr_o           = tpr_reg;
    assign tpr_shadow_o    = shadow_reg;
    assign update_busy_o   = busy_reg;
    assign update_done_o   = done_reg;
    assign tpr_write_err_o = err_reg;
    // Combinational so a store issued alongside the write is held as well.
    assign stall_store_o   = id_is_store_i & ((state_reg != IDLE) | we_acc);

endmodule
